// File: rtl/rptr_empty_prog.sv
// ---------------------------------------------------------------------------
// rptr_empty_prog
//   Read-side pointer and flag logic for an asynchronous FIFO. It keeps the
//   binary read pointer and publishes its Gray-coded form for the write
//   domain. Against the synchronized write pointer it derives the registered
//   empty flag, a programmable almost-empty flag and the occupancy. Reads
//   attempted while empty are rejected. Each rejected read is reported as a
//   one-cycle pulse, a sticky flag and a saturating event counter.
//
// Ports
//   rclk              in   read-domain clock
//   rrst_n            in   asynchronous active-low reset
//   rinc              in   read request
//   rq2_wptr          in   Gray write pointer, already synchronized to rclk
//   ae_thresh         in   runtime almost-empty threshold
//   ae_thresh_en      in   1: use ae_thresh, 0: use AE_DEFAULT
//   ucnt_clr          in   synchronous clear of ucnt and runderflow_sticky
//   raddr             out  binary read address into storage
//   rptr              out  registered Gray read pointer
//   rempty            out  registered empty flag
//   raempty           out  registered almost-empty flag
//   rcount            out  registered occupancy, 0..2**ASIZE
//   runderflow        out  one-cycle pulse on a rejected read
//   runderflow_sticky out  set on any underflow, held until ucnt_clr
//   ucnt              out  saturating underflow event count
//
// Handshake: rinc is a request and ~rempty acts as ready. A read is
// accepted on a rising rclk edge only when both are high. A request made
// while rempty is high is dropped and counted as an underflow.
// ---------------------------------------------------------------------------
module rptr_empty_prog #(
    parameter int ASIZE      = 4,
    parameter int AE_DEFAULT = 2,
    parameter int UCNT_W     = 8
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rinc,
    input  logic [ASIZE:0]    rq2_wptr,
    input  logic [ASIZE:0]    ae_thresh,
    input  logic              ae_thresh_en,
    input  logic              ucnt_clr,
    output logic [ASIZE-1:0]  raddr,
    output logic [ASIZE:0]    rptr,
    output logic              rempty,
    output logic              raempty,
    output logic [ASIZE:0]    rcount,
    output logic              runderflow,
    output logic              runderflow_sticky,
    output logic [UCNT_W-1:0] ucnt
);

    localparam logic [ASIZE:0]    AE_DEF   = (ASIZE+1)'(AE_DEFAULT);
    localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbin_next;
    logic [ASIZE:0] rgray_next;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] cnt_next;
    logic [ASIZE:0] thr;
    logic           accept;
    logic           underflow;

    assign accept    = rinc & ~rempty;
    assign underflow = rinc & rempty;
    assign raddr     = rbin[ASIZE-1:0];

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    assign rbin_next  = rbin + {{ASIZE{1'b0}}, accept};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    // The subtraction wraps modulo 2**(ASIZE+1). With the extra pointer bit,
    // this yields 0..2**ASIZE without special-casing the wrap.
    assign cnt_next   = wbin - rbin_next;
    // Any threshold >= 2**ASIZE is never exceeded by the count, so
    // almost-empty is forced high.
    assign thr        = ae_thresh_en ? ae_thresh : AE_DEF;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rcount  <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
        end else begin
            rbin    <= rbin_next;
            rptr    <= rgray_next;
            rcount  <= cnt_next;
            rempty  <= (rgray_next == rq2_wptr);
            raempty <= (cnt_next <= thr);
        end
    end

    // Underflow reporting. A clear in the same cycle as an underflow wins
    // for the count and the sticky flag, but the pulse is still produced.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow        <= 1'b0;
            runderflow_sticky <= 1'b0;
            ucnt              <= '0;
        end else begin
            runderflow <= underflow;
            if (ucnt_clr) begin
                runderflow_sticky <= 1'b0;
                ucnt              <= '0;
            end else if (underflow) begin
                runderflow_sticky <= 1'b1;
                if (ucnt != UCNT_MAX) begin
                    ucnt <= ucnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rptr_empty_prog.md
RPTR_EMPTY_PROG -- requirements
Module: rptr_empty_prog

Interface
REQ-001 Parameter ASIZE, default 4, address width; FIFO depth = 2**ASIZE; pointers are ASIZE+1 bits.
REQ-002 Parameter AE_DEFAULT, default 2, almost-empty threshold used while ae_thresh_en is low.
REQ-003 Parameter UCNT_W, default 8, width of the underflow event counter.
REQ-004 Clock and reset: one clock, rclk; reset is asynchronous and active-low, rrst_n.
REQ-005 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-006 rrst_n  input  1  asynchronous active-low reset.
REQ-007 rinc  input  1  read request, one entry per cycle when accepted.
REQ-008 rq2_wptr  input  ASIZE+1  Gray write pointer, already synchronized into rclk.
REQ-009 ae_thresh  input  ASIZE+1  runtime almost-empty threshold.
REQ-010 ae_thresh_en  input  1  1 = use ae_thresh, 0 = use AE_DEFAULT.
REQ-011 ucnt_clr  input  1  synchronous clear of the underflow counter and sticky flag.
REQ-012 raddr  output  ASIZE  binary read address into storage.
REQ-013 rptr  output  ASIZE+1  registered Gray read pointer for the write domain.
REQ-014 rempty  output  1  registered empty flag.
REQ-015 raempty  output  1  registered almost-empty flag.
REQ-016 rcount  output  ASIZE+1  registered occupancy, range 0..2**ASIZE.
REQ-017 runderflow  output  1  one-cycle pulse on a rejected read.
REQ-018 runderflow_sticky  output  1  set on any underflow, held until ucnt_clr.
REQ-019 ucnt  output  UCNT_W  saturating count of underflow events.

Function
REQ-020 Read accept = rinc & ~rempty.
- rbin_next = rbin + accept, modulo 2**(ASIZE+1).
- rgray_next = rbin_next ^ (rbin_next >> 1).
REQ-021 Each cycle: rbin <= rbin_next; rptr <= rgray_next; raddr = rbin[ASIZE-1:0].
REQ-022 Convert rq2_wptr to binary, wbin, by prefix XOR from the MSB; this conversion is combinational.
REQ-023 cnt_next = (wbin - rbin_next) modulo 2**(ASIZE+1); rcount <= cnt_next.
REQ-024 rempty <= (rgray_next == rq2_wptr); rempty and rcount==0 agree in every cycle.
REQ-025 Threshold thr = ae_thresh_en ? ae_thresh : AE_DEFAULT.
- raempty <= (cnt_next <= thr).
- raempty is 1 whenever rempty is 1.
REQ-026 The threshold is sampled every cycle; a change affects raempty on the next edge; thr >= 2**ASIZE forces raempty = 1.
REQ-027 Underflow = rinc & rempty.
- runderflow <= underflow.
- rbin and rptr do not change on underflow.
REQ-028 On underflow, runderflow_sticky <= 1 and ucnt <= ucnt + 1, saturating at 2**UCNT_W - 1.
REQ-029 ucnt_clr clears ucnt and runderflow_sticky; if underflow occurs in the same cycle, the clear wins and the count is 0, but the runderflow pulse still occurs.
REQ-030 Wrap-around: the pointer MSB toggles every 2**ASIZE reads; empty and count are correct across wrap.
REQ-031 Simultaneous read accept and rq2_wptr change: both are reflected in cnt_next in the same cycle.
REQ-032 Latency: rempty, raempty, rcount and rptr reflect a read or write-pointer change one rclk edge after it is sampled.
REQ-033 Gray read pointer: consecutive rptr values differ in at most one bit.

Reset
REQ-034 rrst_n low asynchronously sets:
- rbin = 0, rptr = 0, raddr = 0, rcount = 0;
- rempty = 1, raempty = 1;
- runderflow = 0, runderflow_sticky = 0, ucnt = 0.
REQ-035 Reset asserted mid-operation aborts any read immediately; the first edge after release evaluates from zero pointers.
REQ-036 rempty is 1 throughout reset and on the first edge after release when rq2_wptr = 0.

Verification (ASIZE=4, AE_DEFAULT=2)
REQ-037 Reset release with rq2_wptr=0 and rinc=1 for 3 cycles -> rempty=1, rptr=0, runderflow=1 each cycle, ucnt=3, sticky=1.
REQ-038 rq2_wptr = Gray(5) = 5'b00111, then 5 reads, with ae_thresh_en=0:
- rcount sequence 5,4,3,2,1,0;
- raempty rises when rcount=2;
- rempty rises with rcount=0.
REQ-039 Wrap: preload rbin=30 (after 30 reads) with wbin=1, read 3 -> rptr passes Gray 31, 0, 1; rcount 3,2,1,0; rempty=1 at the end.
REQ-040 Full FIFO: wbin = rbin + 16 -> rcount=16, rempty=0, raempty=0; set ae_thresh_en=1, ae_thresh=16 -> raempty=1 on the next edge.
REQ-041 Underflow saturation with UCNT_W=2: 5 underflows -> ucnt=3; ucnt_clr coincident with an underflow -> ucnt=0, sticky=0, runderflow=1.
REQ-042 Assert rrst_n low mid-burst at rcount=7 -> all outputs take their reset values asynchronously, with no rclk edge required.
